// File: rtl/intel_8255_if.sv
// CPU-side control strobes and register select for the 8255 PPI.
// The data bus itself is a plain inout port on the core.
interface intel_8255_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] a;

  modport master (output cs_n, output rd_n, output wr_n, output a);
  modport slave  (input cs_n, input rd_n, input wr_n, input a);
endinterface

// File: rtl/intel_8255.sv
// Intel 8255 PPI subset, mode 0 only. Define INTEL8255_BSR_EN to enable
// port C bit set/reset through control writes with d[7]=0.
module intel_8255 #(
  parameter logic [7:0] CTRL_RESET = 8'h99
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  intel_8255_if.slave      bus,
  inout  wire  [7:0]       io_d,
  input  logic [7:0]       i_pa,
  output logic [7:0]       o_pb,
  input  logic [7:0]       i_pc
);

  logic [7:0] r_ctrl;
  logic [7:0] r_pa_lat;
  logic [7:0] r_pb_lat;
  logic [7:0] r_pc_lat;

  logic       w_wr;
  logic       w_rd_en;
  logic [7:0] w_rd_data;
  logic       w_unused_ctrl;

  assign w_wr    = !bus.cs_n && !bus.wr_n;
  assign w_rd_en = !bus.cs_n && !bus.rd_n && bus.wr_n && (bus.a != 2'd3);

  // Mode-select bits are kept for completeness but never decoded.
  assign w_unused_ctrl = ^{r_ctrl[7:5], r_ctrl[2]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ctrl   <= CTRL_RESET;
      r_pa_lat <= 8'h00;
      r_pb_lat <= 8'h00;
      r_pc_lat <= 8'h00;
    end else if (w_wr) begin
      unique case (bus.a)
        2'd0: r_pa_lat <= io_d;
        2'd1: r_pb_lat <= io_d;
        2'd2: r_pc_lat <= io_d;
        2'd3: begin
          if (io_d[7]) begin
            r_ctrl   <= io_d;
            r_pa_lat <= 8'h00;
            r_pb_lat <= 8'h00;
            r_pc_lat <= 8'h00;
          end else begin
`ifdef INTEL8255_BSR_EN
            r_pc_lat[io_d[3:1]] <= io_d[0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    unique case (bus.a)
      2'd0: w_rd_data = r_ctrl[4] ? i_pa : r_pa_lat;
      2'd1: w_rd_data = r_pb_lat;
      2'd2: begin
        w_rd_data[7:4] = r_ctrl[3] ? i_pc[7:4] : r_pc_lat[7:4];
        w_rd_data[3:0] = r_ctrl[0] ? i_pc[3:0] : r_pc_lat[3:0];
      end
      default: w_rd_data = 8'h00;
    endcase
  end

  assign io_d = w_rd_en ? w_rd_data : 8'hzz;
  assign o_pb = r_ctrl[1] ? 8'h00 : r_pb_lat;

endmodule

// File: tb/tb_intel_8255.sv
// Directed bench for intel_8255; the data bus carries pull-ups so an
// undriven bus reads back as 8'hFF.
module tb_intel_8255;

  logic       clk;
  logic       reset_n;
  logic [7:0] pa;
  logic [7:0] pc;
  logic [7:0] pb;
  logic [7:0] tb_d;
  logic       tb_d_oe;
  wire  [7:0] d_bus;

  int n_checks;
  int n_fail;

`ifdef INTEL8255_BSR_EN
  localparam logic [7:0] BsrSetExp = 8'h20;
`else
  localparam logic [7:0] BsrSetExp = 8'h00;
`endif

  intel_8255_if bus_if ();

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (d_bus[i]);
  end

  assign d_bus = tb_d_oe ? tb_d : 8'hzz;

  intel_8255 u_dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus_if),
    .io_d      (d_bus),
    .i_pa      (pa),
    .o_pb      (pb),
    .i_pc      (pc)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.cs_n = 1'b1;
    bus_if.rd_n = 1'b1;
    bus_if.wr_n = 1'b1;
    bus_if.a    = 2'd0;
    tb_d_oe     = 1'b0;
    tb_d        = 8'h00;
  endtask

  // Holds the strobe across exactly one rising edge.
  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.cs_n = 1'b0;
    bus_if.wr_n = 1'b0;
    bus_if.a    = addr;
    tb_d        = data;
    tb_d_oe     = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    @(negedge clk);
    bus_if.cs_n = 1'b0;
    bus_if.rd_n = 1'b0;
    bus_if.a    = addr;
    #1;
    check_val(tag, d_bus, exp);
    bus_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus_idle();
    pa      = 8'h00;
    pc      = 8'h00;
    reset_n = 1'b0;
    #10;
    check_val("rst_pb", pb, 8'h00);
    check_val("rst_bus_float", d_bus, 8'hFF);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset control word 0x99: PA and PC inputs, PB output.
    pa = 8'hAA;
    bus_read("rd_pa_pins", 2'd0, 8'hAA);
    pc = 8'h55;
    bus_read("rd_pc_pins", 2'd2, 8'h55);
    bus_read("rd_ctrl_float", 2'd3, 8'hFF);

    @(negedge clk);
    bus_if.cs_n = 1'b1;
    bus_if.rd_n = 1'b0;
    bus_if.a    = 2'd2;
    #1;
    check_val("cs_off_float", d_bus, 8'hFF);
    bus_idle();

    bus_write(2'd1, 8'hFF);
    check_val("pb_write", pb, 8'hFF);
    bus_read("rd_pb_lat", 2'd1, 8'hFF);

    // All-output mode word clears every latch.
    bus_write(2'd3, 8'h80);
    check_val("pb_after_ctrl", pb, 8'h00);
    bus_read("rd_pa_lat_clr", 2'd0, 8'h00);
    bus_read("rd_pc_lat_clr", 2'd2, 8'h00);

    bus_write(2'd3, 8'h0B);
    bus_read("bsr_set", 2'd2, BsrSetExp);
    bus_write(2'd3, 8'h0A);
    bus_read("bsr_clr", 2'd2, 8'h00);
    bus_read("bsr_ctrl_kept", 2'd0, 8'h00);

    bus_write(2'd2, 8'h3C);
    bus_read("rd_pc_lat", 2'd2, 8'h3C);

    // rd_n and wr_n both low: the write still lands.
    @(negedge clk);
    bus_if.cs_n = 1'b0;
    bus_if.rd_n = 1'b0;
    bus_if.wr_n = 1'b0;
    bus_if.a    = 2'd0;
    tb_d        = 8'h5A;
    tb_d_oe     = 1'b1;
    @(negedge clk);
    bus_idle();
    bus_read("rdwr_write", 2'd0, 8'h5A);

    bus_write(2'd1, 8'hC3);
    check_val("pb_c3", pb, 8'hC3);
    @(negedge clk);
    bus_if.cs_n = 1'b1;
    bus_if.wr_n = 1'b0;
    bus_if.a    = 2'd1;
    tb_d        = 8'h77;
    tb_d_oe     = 1'b1;
    @(negedge clk);
    bus_idle();
    check_val("cs_off_no_write", pb, 8'hC3);

    // PB as input forces the pins low while the latch still reads back.
    bus_write(2'd3, 8'h82);
    bus_write(2'd1, 8'h11);
    check_val("pb_in_pins", pb, 8'h00);
    bus_read("pb_in_lat", 2'd1, 8'h11);

    // Reset during an active write, between clock edges.
    bus_write(2'd3, 8'h80);
    bus_write(2'd1, 8'hFF);
    check_val("pb_pre_rst", pb, 8'hFF);
    @(negedge clk);
    bus_if.cs_n = 1'b0;
    bus_if.wr_n = 1'b0;
    bus_if.a    = 2'd1;
    tb_d        = 8'hFF;
    tb_d_oe     = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check_val("rst_async_pb", pb, 8'h00);
    @(posedge clk);
    #1;
    check_val("rst_hold_pb", pb, 8'h00);
    bus_idle();
    @(negedge clk);
    reset_n = 1'b1;
    pc = 8'hE7;
    bus_read("post_rst_pc", 2'd2, 8'hE7);
    bus_read("post_rst_pb_lat", 2'd1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
